sha256_msg_padder: RTL and testbench

SHA256_MSG_PADDER -- requirements
Module: sha256_msg_padder

---
 rtl/sha256_msg_padder.sv | 236 +++++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: turns a byte stream into padded 512-bit SHA-256 blocks,
// presented as sixteen 32-bit schedule words per block. Message bytes are
// packed big-endian into words, then the 0x80 terminator, zero fill and the
// 64-bit big-endian bit length are appended.
module sha256_msg_padder (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] w_data,
    output logic [3:0]  w_idx,
    output logic        w_valid,
    input  logic        w_ready,
    output logic        w_blk_end,
    output logic        w_last
);

    typedef enum logic [2:0] {
        ST_ACCEPT = 3'd0,
        ST_PAD    = 3'd1,
        ST_ZERO   = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_LEN_LO = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] asm_q, asm_d;        // word being assembled from bytes
    logic [1:0]  lane_q, lane_d;      // next free byte lane, 0 = [31:24]
    logic [63:0] cnt_q, cnt_d;        // accepted byte count, modulo 2^61
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_idx_q, w_idx_d;    // index of the word shown / next shown
    logic        w_valid_q, w_valid_d;
    logic        w_blk_end_q, w_blk_end_d;
    logic        w_last_q, w_last_d;

    logic        s_accept_s;
    logic        w_accept_s;
    logic [3:0]  idx_next_s;
    logic [63:0] bitlen_s;

    // Place one byte into the given lane of a word, leaving other lanes intact.
    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  b);
        logic [31:0] res;
        case (lane)
            2'd0:    res = {b, word[23:0]};
            2'd1:    res = {word[31:24], b, word[15:0]};
            2'd2:    res = {word[31:16], b, word[7:0]};
            2'd3:    res = {word[31:8], b};
            default: res = word;
        endcase
        return res;
    endfunction

    assign s_ready    = (state_q == ST_ACCEPT) && !w_valid_q;
    assign s_accept_s = s_valid && s_ready;
    assign w_accept_s = w_valid_q && w_ready;
    assign idx_next_s = w_idx_q + 4'd1;
    // Only 61 counter bits are meaningful, so shifting by 3 never loses bits.
    assign bitlen_s   = {cnt_q[60:0], 3'b000};

    assign w_data    = w_data_q;
    assign w_idx     = w_idx_q;
    assign w_valid   = w_valid_q;
    assign w_blk_end = w_blk_end_q;
    assign w_last    = w_last_q;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= ST_ACCEPT;
            asm_q       <= 32'd0;
            lane_q      <= 2'd0;
            cnt_q       <= 64'd0;
            w_data_q    <= 32'd0;
            w_idx_q     <= 4'd0;
            w_valid_q   <= 1'b0;
            w_blk_end_q <= 1'b0;
            w_last_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            asm_q       <= asm_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            w_data_q    <= w_data_d;
            w_idx_q     <= w_idx_d;
            w_valid_q   <= w_valid_d;
            w_blk_end_q <= w_blk_end_d;
            w_last_q    <= w_last_d;
        end
    end

    // Next-state selection; padding states only advance when a new word is loaded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: begin
                if (s_accept_s && s_last) begin
                    state_d = ST_PAD;
                end else begin
                    state_d = ST_ACCEPT;
                end
            end
            ST_PAD: begin
                if (!w_valid_q) begin
                    state_d = (idx_next_s == 4'd14) ? ST_LEN_HI : ST_ZERO;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_ZERO: begin
                if (!w_valid_q && (idx_next_s == 4'd14)) begin
                    state_d = ST_LEN_HI;
                end else begin
                    state_d = ST_ZERO;
                end
            end
            ST_LEN_HI: begin
                if (!w_valid_q) begin
                    state_d = ST_LEN_LO;
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (w_accept_s && w_last_q) begin
                    state_d = ST_ACCEPT;
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Byte packing, word generation and output handshake bookkeeping.
    always_comb begin
        asm_d       = asm_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        w_data_d    = w_data_q;
        w_idx_d     = w_idx_q;
        w_valid_d   = w_valid_q;
        w_blk_end_d = w_blk_end_q;
        w_last_d    = w_last_q;

        // A consumed word frees the output register and advances the index.
        if (w_accept_s) begin
            w_valid_d   = 1'b0;
            w_idx_d     = idx_next_s;
            w_blk_end_d = 1'b0;
            w_last_d    = 1'b0;
        end else begin
            w_valid_d   = w_valid_q;
            w_idx_d     = w_idx_q;
        end

        // New words are loaded only while the output register is empty, so
        // w_idx_q is always the index of the word being loaded.
        case (state_q)
            ST_ACCEPT: begin
                if (s_accept_s) begin
                    cnt_d = {3'b000, cnt_q[60:0] + 61'd1};
                    if (lane_q == 2'd3) begin
                        w_data_d    = lane_insert(asm_q, lane_q, s_data);
                        w_valid_d   = 1'b1;
                        w_blk_end_d = (w_idx_q == 4'd15);
                        w_last_d    = 1'b0;
                        asm_d       = 32'd0;
                        lane_d      = 2'd0;
                    end else begin
                        asm_d  = lane_insert(asm_q, lane_q, s_data);
                        lane_d = lane_q + 2'd1;
                    end
                end else begin
                    asm_d = asm_q;
                end
            end
            ST_PAD: begin
                if (!w_valid_q) begin
                    // Unused lower lanes are already zero after each word.
                    w_data_d    = lane_insert(asm_q, lane_q, 8'h80);
                    w_valid_d   = 1'b1;
                    w_blk_end_d = (w_idx_q == 4'd15);
                    w_last_d    = 1'b0;
                    asm_d       = 32'd0;
                    lane_d      = 2'd0;
                end else begin
                    asm_d = asm_q;
                end
            end
            ST_ZERO: begin
                if (!w_valid_q) begin
                    w_data_d    = 32'd0;
                    w_valid_d   = 1'b1;
                    w_blk_end_d = (w_idx_q == 4'd15);
                    w_last_d    = 1'b0;
                end else begin
                    asm_d = asm_q;
                end
            end
            ST_LEN_HI: begin
                if (!w_valid_q) begin
                    w_data_d    = bitlen_s[63:32];
                    w_valid_d   = 1'b1;
                    w_blk_end_d = (w_idx_q == 4'd15);
                    w_last_d    = 1'b0;
                end else begin
                    asm_d = asm_q;
                end
            end
            ST_LEN_LO: begin
                if (!w_valid_q) begin
                    w_data_d    = bitlen_s[31:0];
                    w_valid_d   = 1'b1;
                    w_blk_end_d = (w_idx_q == 4'd15);
                    w_last_d    = 1'b1;
                end else if (w_accept_s && w_last_q) begin
                    cnt_d  = 64'd0;
                    asm_d  = 32'd0;
                    lane_d = 2'd0;
                end else begin
                    asm_d = asm_q;
                end
            end
            default: begin
                asm_d  = 32'd0;
                lane_d = 2'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder: messages are padded by a
// byte-queue reference model and every consumed word is compared.
module tb_sha256_msg_padder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] w_data;
    logic [3:0]  w_idx;
    logic        w_valid;
    logic        w_ready;
    logic        w_blk_end;
    logic        w_last;

    int n_vec;
    int n_err;

    logic [7:0]  msg[$];
    logic [31:0] exp_w[$];
    logic [31:0] got_w[$];

    sha256_msg_padder dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_blk_end (w_blk_end),
        .w_last    (w_last)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // SHA-256 padding straight from the byte-level rule.
    task automatic build_expected();
        logic [7:0]  q[$];
        logic [63:0] bitlen;
        q = msg;
        bitlen = 64'(msg.size()) * 64'd8;
        q.push_back(8'h80);
        while ((q.size() % 64) != 56) q.push_back(8'h00);
        for (int i = 7; i >= 0; i--) q.push_back(bitlen[8*i +: 8]);
        exp_w.delete();
        for (int i = 0; i < q.size() / 4; i++)
            exp_w.push_back({q[4*i], q[4*i+1], q[4*i+2], q[4*i+3]});
    endtask

    task automatic drive_bytes(input bit with_last);
        int tries;
        for (int i = 0; i < msg.size(); i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
                @(negedge clk_in);
            end
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = with_last && (i == msg.size() - 1);
            tries   = 0;
            #1;
            while (!s_ready && tries < 5000) begin
                @(negedge clk_in);
                #1;
                tries++;
            end
            if (!s_ready) check("s_ready_timeout", 64'(s_ready), 64'd1);
            @(negedge clk_in);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic collect(input int stall_at);
        int k;
        int cyc;
        bit stalled;
        logic [31:0] hd;
        logic [3:0]  hi;
        k = 0;
        cyc = 0;
        stalled = 1'b0;
        while (k < exp_w.size() && cyc < 20000) begin
            @(negedge clk_in);
            cyc++;
            if (k == stall_at && !stalled && w_valid) begin
                w_ready = 1'b0;
                hd = w_data;
                hi = w_idx;
                stalled = 1'b1;
                repeat (5) begin
                    @(negedge clk_in);
                    #1;
                    check("stall_data", 64'(w_data), 64'(hd));
                    check("stall_idx", 64'(w_idx), 64'(hi));
                    check("stall_sready", 64'(s_ready), 64'd0);
                end
            end else begin
                w_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (w_valid && w_ready) begin
                    check("w_data", 64'(w_data), 64'(exp_w[k]));
                    check("w_idx", 64'(w_idx), 64'(k % 16));
                    check("w_blk_end", 64'(w_blk_end), 64'((k % 16) == 15));
                    check("w_last", 64'(w_last), 64'(k == exp_w.size() - 1));
                    got_w.push_back(w_data);
                    k++;
                end
            end
        end
        check("word_count", 64'(k), 64'(exp_w.size()));
        @(negedge clk_in);
        w_ready = 1'b0;
    endtask

    task automatic run_msg(input int stall_at);
        build_expected();
        got_w.delete();
        fork
            drive_bytes(1'b1);
            collect(stall_at);
        join
        repeat (3) @(negedge clk_in);
        #1;
        check("idle_after_msg", 64'(w_valid), 64'd0);
        check("sready_after_msg", 64'(s_ready), 64'd1);
    endtask

    task automatic random_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_in  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        w_ready = 1'b0;
        repeat (2) @(negedge clk_in);
        #1;
        check("rst_w_valid", 64'(w_valid), 64'd0);
        check("rst_w_idx", 64'(w_idx), 64'd0);
        check("rst_w_data", 64'(w_data), 64'd0);
        check("rst_w_blk_end", 64'(w_blk_end), 64'd0);
        check("rst_w_last", 64'(w_last), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        @(negedge clk_in);

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(-1);
        check("abc_w0", 64'(got_w[0]), 64'h61626380);
        check("abc_w15", 64'(got_w[15]), 64'h18);

        // 55 bytes: pad and length fit in one block
        random_msg(55);
        run_msg(-1);
        check("m55_w13_pad", 64'(got_w[13][7:0]), 64'h80);
        check("m55_w14", 64'(got_w[14]), 64'd0);
        check("m55_w15", 64'(got_w[15]), 64'h1B8);

        // 56 bytes: spills into a second block, with an output stall
        random_msg(56);
        run_msg(8);
        check("m56_w14", 64'(got_w[14]), 64'h80000000);
        check("m56_w15", 64'(got_w[15]), 64'd0);
        check("m56_w31", 64'(got_w[31]), 64'h1C0);

        // 64 bytes: pad word opens the second block
        random_msg(64);
        run_msg(-1);
        check("m64_w16", 64'(got_w[16]), 64'h80000000);
        check("m64_w31", 64'(got_w[31]), 64'h200);

        // random lengths and stall points
        for (int t = 0; t < 12; t++) begin
            random_msg($urandom_range(1, 200));
            run_msg($urandom_range(0, 12));
        end

        // reset in the middle of a message, then "abc"
        random_msg(6);
        w_ready = 1'b1;
        drive_bytes(1'b0);
        rst_in = 1'b0;
        #1;
        check("midrst_w_valid", 64'(w_valid), 64'd0);
        check("midrst_w_idx", 64'(w_idx), 64'd0);
        check("midrst_w_data", 64'(w_data), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (4) begin
            @(negedge clk_in);
            #1;
            check("postrst_no_word", 64'(w_valid), 64'd0);
        end
        w_ready = 1'b0;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(-1);
        check("rst_abc_w0", 64'(got_w[0]), 64'h61626380);
        check("rst_abc_w15", 64'(got_w[15]), 64'h18);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
